// File: rtl/adder_pkg.sv
// Shared definitions for the FIFO-fed adder sequencer: state encodings and common widths.
package adder_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        OUT  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/adder_seq_acc.sv
// Accumulator with sticky carry-out; clear has priority over accumulate.
module adder_seq_acc
    import adder_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc,
    output logic              ovf
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, din};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= sum[DATA_W-1:0];
            ovf <= ovf | sum[DATA_W];
        end
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencer: pops OPND_N operands from a show-ahead FIFO, accumulates them,
// writes the sum to the register file at an auto-incrementing address, then pulses op_done.
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OPND_N = 2,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_start,
    input  logic              op_clear,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_read,
    output logic              Register_we,
    output logic [ADDR_W-1:0] Register_addr,
    output logic [DATA_W-1:0] out_result,
    output logic              ovf,
    output logic              op_done,
    output logic [1:0]        state,
    output logic [1:0]        count
);

    localparam logic [CNT_W-1:0] OPND_C = CNT_W'(OPND_N);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic               start_go;

    always_comb begin
        state_d     = state_q;
        fifo_read   = 1'b0;
        Register_we = 1'b0;
        op_done     = 1'b0;
        start_go    = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_start) begin
                    state_d  = EXEC;
                    start_go = 1'b1;
                end
            end
            EXEC: begin
                if (!fifo_empty && (count_q < OPND_C)) begin
                    fifo_read = 1'b1;
                    if (count_q + CNT_W'(1) == OPND_C) state_d = OUT;
                end
            end
            OUT: begin
                Register_we = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                op_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Clear overrides every transition and suppresses any pop or write this cycle
        if (op_clear) begin
            state_d     = IDLE;
            fifo_read   = 1'b0;
            Register_we = 1'b0;
            start_go    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (op_clear) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (start_go) count_q <= '0;
                else if (fifo_read) count_q <= count_q + CNT_W'(1);
                if (Register_we) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
        end
    end

    adder_seq_acc #(
        .DATA_W (DATA_W)
    ) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (op_clear | start_go),
        .en      (fifo_read),
        .din     (fifo_rd_data),
        .acc     (out_result),
        .ovf     (ovf)
    );

    assign state         = state_q;
    assign count         = count_q;
    assign Register_addr = wr_ptr_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: stimulus pushes expected writes, a monitor checks them.
module tb_adder_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_start = 1'b0;
    logic        op_clear = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;
    logic        fifo_read;
    logic        Register_we;
    logic [3:0]  Register_addr;
    logic [31:0] out_result;
    logic        ovf;
    logic        op_done;
    logic [1:0]  state;
    logic [1:0]  count;

    always #5 clk = ~clk;

    adder_seq_ctrl #(
        .DATA_W (32),
        .OPND_N (2),
        .ADDR_W (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .op_start      (op_start),
        .op_clear      (op_clear),
        .fifo_empty    (fifo_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_read     (fifo_read),
        .Register_we   (Register_we),
        .Register_addr (Register_addr),
        .out_result    (out_result),
        .ovf           (ovf),
        .op_done       (op_done),
        .state         (state),
        .count         (count)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] res;
        logic        ov;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fifo_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          pop_cnt = 0;
    logic        prev_we = 1'b0;
    logic [3:0]  exp_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void fifo_upd();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endfunction

    initial fifo_upd();

    // Show-ahead FIFO model: pop decided at the edge, head updated just after it
    always @(posedge clk) begin
        if (fifo_read) begin
            pop_cnt++;
            #1;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            fifo_upd();
        end
    end

    // Monitor: compare every register-file write against the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (Register_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(Register_addr), 64'(e.addr));
                    check("wr_result", 64'(out_result), 64'(e.res));
                    check("wr_ovf", 64'(ovf), 64'(e.ov));
                end
            end
            if (op_done) begin
                done_cnt++;
                check("done_after_we", 64'(prev_we), 64'(1));
            end
            prev_we = Register_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] d);
        fifo_q.push_back(d);
        fifo_upd();
    endtask

    task automatic expect_wr(input logic [31:0] res, input logic ov);
        exp_q.push_back('{exp_addr, res, ov});
        exp_addr = exp_addr + 4'd1;
    endtask

    task automatic wait_done(input int n0);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > n0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("done_timeout", 64'(0), 64'(1));
        step();
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic ov);
        int n0;
        push(a);
        push(b);
        expect_wr(res, ov);
        n0 = done_cnt;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        wait_done(n0);
    endtask

    task automatic do_clear();
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
        exp_addr = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_read"}, 64'(fifo_read), 64'(0));
        check({tag, "_we"}, 64'(Register_we), 64'(0));
        check({tag, "_addr"}, 64'(Register_addr), 64'(0));
        check({tag, "_result"}, 64'(out_result), 64'(0));
        check({tag, "_ovf"}, 64'(ovf), 64'(0));
        check({tag, "_done"}, 64'(op_done), 64'(0));
        check({tag, "_state"}, 64'(state), 64'(0));
        check({tag, "_count"}, 64'(count), 64'(0));
    endtask

    initial begin
        int n0;
        int p0;

        // Reset state
        repeat (2) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // 1: {5,7} with cycle-by-cycle timeline
        push(32'd5);
        push(32'd7);
        expect_wr(32'd12, 1'b0);
        n0 = done_cnt;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        check("t1_state_exec", 64'(state), 64'(1));
        check("t1_read0", 64'(fifo_read), 64'(1));
        step();
        check("t1_read1", 64'(fifo_read), 64'(1));
        check("t1_count1", 64'(count), 64'(1));
        step();
        check("t1_we", 64'(Register_we), 64'(1));
        check("t1_state_out", 64'(state), 64'(2));
        step();
        check("t1_done", 64'(op_done), 64'(1));
        step();
        check("t1_idle", 64'(state), 64'(0));
        check("t1_done_cnt", 64'(done_cnt - n0), 64'(1));

        // 2: underflow stall between operands
        p0 = pop_cnt;
        push(32'h0000_1234);
        expect_wr(32'h0000_1334, 1'b0);
        n0 = done_cnt;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("t2_stall_read", 64'(fifo_read), 64'(0));
            check("t2_stall_count", 64'(count), 64'(1));
            check("t2_stall_state", 64'(state), 64'(1));
            step();
        end
        push(32'h0000_0100);
        wait_done(n0);
        check("t2_pops", 64'(pop_cnt - p0), 64'(2));

        // 3: overflow then a clean op
        run_op(32'hFFFF_FFFF, 32'h2, 32'h1, 1'b1);
        run_op(32'd3, 32'd4, 32'd7, 1'b0);

        // 4: address wrap over 17 ops
        do_clear();
        n0 = done_cnt;
        for (int unsigned i = 0; i < 17; i++)
            run_op(i, 32'd100, i + 32'd100, 1'b0);
        check("t4_done_cnt", 64'(done_cnt - n0), 64'(17));
        check("t4_addr_after", 64'(Register_addr), 64'(1));

        // 5a: clear in EXEC after one pop
        n0 = done_cnt;
        push(32'd10);
        push(32'd20);
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        step();
        check("t5_count1", 64'(count), 64'(1));
        op_clear = 1'b1;
        #1;
        check("t5_read_gated", 64'(fifo_read), 64'(0));
        step();
        op_clear = 1'b0;
        exp_addr = '0;
        check("t5_state", 64'(state), 64'(0));
        check("t5_acc", 64'(out_result), 64'(0));
        check("t5_addr", 64'(Register_addr), 64'(0));
        fifo_q.delete();
        fifo_upd();

        // 5b: clear in OUT after one completed op
        run_op(32'd1, 32'd1, 32'd2, 1'b0);
        check("t5_addr_one", 64'(Register_addr), 64'(1));
        n0 = done_cnt;
        push(32'd1);
        push(32'd2);
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        step();
        step();
        check("t5_in_out", 64'(state), 64'(2));
        op_clear = 1'b1;
        #1;
        check("t5_we_gated", 64'(Register_we), 64'(0));
        step();
        op_clear = 1'b0;
        exp_addr = '0;
        check("t5b_state", 64'(state), 64'(0));
        check("t5b_addr", 64'(Register_addr), 64'(0));
        check("t5b_acc", 64'(out_result), 64'(0));
        step();
        check("t5_no_done", 64'(done_cnt - n0), 64'(0));

        // 6: op_start held through a whole op
        push(32'd1);
        push(32'd2);
        push(32'd3);
        push(32'd4);
        expect_wr(32'd3, 1'b0);
        expect_wr(32'd7, 1'b0);
        op_start = 1'b1;
        step();
        check("t6_exec", 64'(state), 64'(1));
        step();
        step();
        check("t6_out", 64'(state), 64'(2));
        step();
        check("t6_done", 64'(state), 64'(3));
        step();
        check("t6_back_idle", 64'(state), 64'(0));
        step();
        check("t6_restart", 64'(state), 64'(1));
        op_start = 1'b0;
        n0 = done_cnt;
        wait_done(n0);

        // 6b: async reset mid-EXEC
        n0 = done_cnt;
        push(32'd9);
        push(32'd9);
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        step();
        check("t6_pre_reset_count", 64'(count), 64'(1));
        #1 reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        fifo_q.delete();
        fifo_upd();
        exp_addr = '0;
        step();
        check("t6_no_done", 64'(done_cnt - n0), 64'(0));
        run_op(32'd100, 32'd23, 32'd123, 1'b0);

        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
